ita_output_controller: RTL and testbench

Sequencer that drains the output FIFO (filled by the requantizer push path) into the ITA output stream. It pops one word per cycle whenever the FIFO is non-empty and the downstream register slot is free, and counts words per tile. It marks the final word of each tile with `last_o` and pulses `done_o` once the tile has fully left the block. It sits between the output FIFO read port and the top-level output handshake interface.

---
 rtl/ita_output_controller.sv | 145 ++++++++++++++
 tb/tb_ita_output_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_output_controller.sv
// -----------------------------------------------------------------------------
// ita_output_controller
//
// Drains the first-word-fall-through output FIFO into the ITA output stream.
// One word is popped per cycle while the FIFO has data and the single output
// register slot is free (or being emptied in the same cycle). The block counts
// words per tile, tags the final beat with last_o and pulses done_o once that
// beat has been accepted downstream.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       start a tile (honoured only when idle); latches tile_len_i
//   clear_i       synchronous abort back to idle, drops the output slot
//   tile_len_i    words in the tile, 0 = empty tile
//   fifo_empty_i  FIFO empty; fifo_data_i valid whenever low
//   fifo_data_i   FIFO head word
//   pop_fifo_o    FIFO read strobe (combinational)
//   valid_o       output beat valid
//   ready_i       downstream accepts the beat
//   data_o        output beat
//   last_o        final beat of the tile, qualified by valid_o
//   busy_o        high whenever not idle
//   done_o        one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module ita_output_controller #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  tile_len_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              pop_fifo_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_popped;
  logic [CNT_W-1:0]    w_popped_inc;
  logic                r_valid;
  logic                r_last;
  logic [DATA_W-1:0]   r_data;
  logic                r_busy;
  logic                r_done;
  logic                w_pop;
  logic                w_accept;
  logic                w_final_pop;

  assign w_accept     = r_valid && ready_i;
  assign w_popped_inc = r_popped + CNT_W'(1);

  // The slot may be refilled in the same cycle its current beat is accepted,
  // which is what gives one beat per cycle. clear_i suppresses the pop so no
  // FIFO word is lost on an abort.
  assign w_pop = (r_state == S_RUN) && !clear_i && !fifo_empty_i &&
                 (r_popped != r_len) && (!r_valid || ready_i);

  assign w_final_pop = w_pop && (w_popped_inc == r_len);

  // NOTE: every signal driven in always_comb gets a default on the first line,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (start_i) w_state_nxt = (tile_len_i == '0) ? S_DONE : S_RUN;
        S_RUN:   if (w_final_pop) w_state_nxt = S_FLUSH;
        S_FLUSH: if (w_accept) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_len    <= '0;
      r_popped <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      // NOTE: the output data register is reset too, so data_o is defined
      // (all zero) straight out of reset rather than left as X.
      r_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // busy/done are registered off the next state so they align with it.
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);

      if (clear_i) begin
        r_popped <= '0;
        r_valid  <= 1'b0;
        r_last   <= 1'b0;
      end else begin
        if (r_state == S_IDLE && start_i) begin
          r_len    <= tile_len_i;
          r_popped <= '0;
        end

        if (w_pop) begin
          r_data   <= fifo_data_i;
          r_valid  <= 1'b1;
          r_last   <= (w_popped_inc == r_len);
          r_popped <= w_popped_inc;
        end else if (w_accept) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      end
    end
  end

  assign pop_fifo_o = w_pop;
  assign valid_o    = r_valid;
  assign data_o     = r_data;
  assign last_o     = r_last;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_ita_output_controller.sv
// -----------------------------------------------------------------------------
// tb_ita_output_controller
//
// Bench for ita_output_controller. A queue models the FWFT output FIFO; the
// expected beat stream of a tile is simply the first tile_len words that the
// FIFO will hold, in order, and done_o is expected one cycle after the last
// accepted beat.
// -----------------------------------------------------------------------------
module tb_ita_output_controller;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 16;

  logic              clk_i;
  logic              rst_ni;
  logic              start_i;
  logic              clear_i;
  logic [CNT_W-1:0]  tile_len_i;
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_data_i;
  logic              pop_fifo_o;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic              last_o;
  logic              busy_o;
  logic              done_o;

  ita_output_controller #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .clear_i      (clear_i),
    .tile_len_i   (tile_len_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .pop_fifo_o   (pop_fifo_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int len;
    int prefill;
    bit rnd_ready;
    bit restart;
    bit timing;
    int exp_pops;
    int exp_left;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fifo_q[$];
  int                arr_t[$];
  logic [DATA_W-1:0] arr_w[$];
  int                valid_rels[$];

  // Values sampled in the cycle that the last step() completed.
  logic              s_pop, s_valid, s_ready, s_last, s_busy, s_done;
  logic [DATA_W-1:0] s_data;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Sample the settled outputs for the current cycle, clock, then apply the
  // FIFO pop. Leaves time at posedge + 1.
  task automatic step();
    #1;
    s_pop   = pop_fifo_o;
    s_valid = valid_o;
    s_ready = ready_i;
    s_data  = data_o;
    s_last  = last_o;
    s_busy  = busy_o;
    s_done  = done_o;
    if (s_pop && fifo_empty_i) check("pop_while_empty", 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    if (s_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic run_tile(input int len, input bit rnd, input bit restart,
                          input bit timing, input int exp_pops, input int exp_left);
    logic [DATA_W-1:0] expq[$];
    logic [DATA_W-1:0] prev_data;
    bit   prev_hold;
    int   pops, acc_n, dones, done_rel, last_acc;

    foreach (fifo_q[i]) expq.push_back(fifo_q[i]);
    foreach (arr_w[i])  expq.push_back(arr_w[i]);
    while (expq.size() > len) void'(expq.pop_back());
    valid_rels.delete();
    pops = 0; acc_n = 0; dones = 0; done_rel = -1; last_acc = -1;
    prev_hold = 1'b0; prev_data = '0;

    tile_len_i = CNT_W'(len);
    start_i    = 1'b1;
    ready_i    = 1'b1;
    step();
    start_i = 1'b0;
    check("pop_in_start_cycle", s_pop, 1'b0);

    for (int rel = 0; rel < 400 && !(done_rel >= 0 && rel > done_rel + 1); rel++) begin
      while (arr_t.size() != 0 && arr_t[0] == rel) begin
        fifo_q.push_back(arr_w.pop_front());
        void'(arr_t.pop_front());
      end
      drive_fifo();
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (restart && rel == 1) begin
        start_i    = 1'b1;
        tile_len_i = CNT_W'(len + 3);
      end else begin
        start_i = 1'b0;
      end
      step();
      if (prev_hold) begin
        check("hold_valid", s_valid, 1'b1);
        check("hold_data", s_data, prev_data);
      end
      prev_hold = s_valid && !s_ready;
      prev_data = s_data;
      if (s_pop) pops++;
      if (s_valid) valid_rels.push_back(rel);
      if (s_valid && s_ready) begin
        if (acc_n < expq.size()) check("beat_data", s_data, expq[acc_n]);
        else check("extra_beat", acc_n, expq.size());
        check("beat_last", s_last, (acc_n == len - 1));
        acc_n++;
        last_acc = rel;
        if (timing) check("beat_cycle", rel, acc_n);
      end
      if (s_done) begin
        dones++;
        if (done_rel < 0) done_rel = rel;
      end
      if (done_rel >= 0 && rel == done_rel + 1) check("busy_after_done", s_busy, 1'b0);
    end
    start_i = 1'b0;
    ready_i = 1'b1;

    check("done_seen", (done_rel >= 0), 1'b1);
    check("done_count", dones, 1);
    check("done_cycle", done_rel, (len == 0) ? 0 : last_acc + 1);
    check("pop_count", pops, exp_pops);
    check("beat_count", acc_n, expq.size());
    check("fifo_left", fifo_q.size(), exp_left);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"},   pop_fifo_o, 1'b0);
    check({tag, "_valid"}, valid_o,    1'b0);
    check({tag, "_last"},  last_o,     1'b0);
    check({tag, "_busy"},  busy_o,     1'b0);
    check({tag, "_done"},  done_o,     1'b0);
    check({tag, "_data"},  data_o,     '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [DATA_W-1:0] base;

    rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
    tile_len_i = '0;
    drive_fifo();
    #22;
    check_all_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // len, prefill, rnd_ready, restart, timing, exp_pops, exp_left
    vecs.push_back('{4, 4, 1'b0, 1'b0, 1'b1, 4, 0});  // basic tile, words 0x1..0x4
    vecs.push_back('{4, 4, 1'b1, 1'b0, 1'b0, 4, 0});  // backpressure
    vecs.push_back('{1, 1, 1'b0, 1'b0, 1'b1, 1, 0});  // single beat
    vecs.push_back('{4, 6, 1'b0, 1'b0, 1'b1, 4, 2});  // words left over
    vecs.push_back('{0, 3, 1'b0, 1'b0, 1'b0, 0, 3});  // empty tile
    vecs.push_back('{5, 5, 1'b0, 1'b1, 1'b1, 5, 0});  // start during RUN ignored
    vecs.push_back('{6, 8, 1'b1, 1'b1, 1'b0, 6, 2});
    for (int k = 0; k < 10; k++) begin
      int l, p;
      l = $urandom_range(1, 12);
      p = l + $urandom_range(0, 3);
      vecs.push_back('{l, p, 1'b1, 1'($urandom_range(0, 1)), 1'b0, l, p - l});
    end

    for (int v = 0; v < vecs.size(); v++) begin
      fifo_q.delete();
      base = (v == 0) ? DATA_W'(1) : rand_word();
      for (int i = 0; i < vecs[v].prefill; i++) fifo_q.push_back(base + DATA_W'(i));
      drive_fifo();
      run_tile(vecs[v].len, vecs[v].rnd_ready, vecs[v].restart, vecs[v].timing,
               vecs[v].exp_pops, vecs[v].exp_left);
    end

    // Starved FIFO: words appear at relative cycles 0, 5, 9.
    fifo_q.delete();
    drive_fifo();
    arr_t = '{0, 5, 9};
    arr_w = '{rand_word(), rand_word(), rand_word()};
    run_tile(3, 1'b0, 1'b0, 1'b0, 3, 0);
    check("starved_valid_n", valid_rels.size(), 3);
    if (valid_rels.size() == 3) begin
      check("starved_valid0", valid_rels[0], 1);
      check("starved_valid1", valid_rels[1], 6);
      check("starved_valid2", valid_rels[2], 10);
    end

    // Abort after two accepted beats of a five-word tile.
    fifo_q.delete();
    for (int i = 0; i < 5; i++) fifo_q.push_back(rand_word());
    drive_fifo();
    tile_len_i = CNT_W'(5); start_i = 1'b1; ready_i = 1'b1;
    step();
    start_i = 1'b0;
    step();                       // pop w0
    step();                       // pop w1, accept w0
    clear_i = 1'b1;
    step();                       // accept w1, pop suppressed
    check("clear_cycle_pop", s_pop, 1'b0);
    check("clear_cycle_accept", s_valid && s_ready, 1'b1);
    clear_i = 1'b0;
    step();
    check("after_clear_valid", s_valid, 1'b0);
    check("after_clear_busy", s_busy, 1'b0);
    check("after_clear_done", s_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_clear_no_done", s_done, 1'b0);
    end
    check("after_clear_fifo_left", fifo_q.size(), 3);
    run_tile(2, 1'b0, 1'b0, 1'b1, 2, 1);

    // Asynchronous reset in the middle of a tile.
    fifo_q.delete();
    for (int i = 0; i < 5; i++) fifo_q.push_back(rand_word());
    drive_fifo();
    tile_len_i = CNT_W'(5); start_i = 1'b1; ready_i = 1'b0;
    step();
    start_i = 1'b0;
    step();
    step();
    check("pre_reset_valid", s_valid, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset");
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_reset_idle_busy", s_busy, 1'b0);
      check("post_reset_no_done", s_done, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
